// File: rtl/if_id_fetch_queue.sv
// IF->ID decoupling FIFO: buffers up to DEPTH fetched {pc, inst} pairs and
// presents the oldest to ID, or an all-zero NOP bubble when empty.
module if_id_fetch_queue #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned INST_W   = 32,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned ID_STALL = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [5:0]                   stall,
  input  logic                         flush,
  input  logic                         if_valid,
  input  logic [ADDR_W-1:0]            if_pc,
  input  logic [INST_W-1:0]            if_inst,
  output logic                         if_ready,
  output logic                         stallreq_if,
  output logic                         id_valid,
  output logic [ADDR_W-1:0]            id_pc,
  output logic [INST_W-1:0]            id_inst,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned ENT_W = ADDR_W + INST_W;

  logic [ENT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [ENT_W-1:0] head;
  logic             unused_stall;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = if_valid & ~full;
  assign pop   = ~empty & ~stall[ID_STALL];

  // Only the ID stall bit matters here; IF freezing is done by ctrl.
  assign unused_stall = ^stall;

  assign if_ready    = ~full;
  assign stallreq_if = full;

  // Head is read straight from storage; empty forces a zero NOP bubble.
  assign head     = mem[rd_ptr];
  assign id_valid = ~empty;
  assign id_pc    = empty ? '0 : head[ENT_W-1:INST_W];
  assign id_inst  = empty ? '0 : head[INST_W-1:0];

  // Pointer/count state; flush discards any same-cycle push and pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage needs no reset; count decides which entries are live.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= {if_pc, if_inst};
  end

endmodule

// File: tb/tb_if_id_fetch_queue.sv
// Directed self-checking bench for if_id_fetch_queue (DEPTH=4).
module tb_if_id_fetch_queue;

  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_ready;
  logic        stallreq_if;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;

  if_id_fetch_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(4), .ID_STALL(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst),
    .if_ready(if_ready), .stallreq_if(stallreq_if),
    .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return 32'hA5A5_0000 | pc;
  endfunction

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] pc);
    if_valid = 1'b1;
    if_pc    = pc;
    if_inst  = inst_of(pc);
  endtask

  task automatic idle();
    if_valid = 1'b0;
    if_pc    = '0;
    if_inst  = '0;
  endtask

  task automatic head_is(input string tag, input logic [31:0] pc, input logic [2:0] cnt);
    check({tag, "_pc"},    64'(id_pc),    64'(pc));
    check({tag, "_inst"},  64'(id_inst),  64'(inst_of(pc)));
    check({tag, "_valid"}, 64'(id_valid), 64'(1));
    check({tag, "_count"}, 64'(count),    64'(cnt));
  endtask

  task automatic empty_is(input string tag);
    check({tag, "_valid"}, 64'(id_valid), 64'(0));
    check({tag, "_pc"},    64'(id_pc),    64'(0));
    check({tag, "_inst"},  64'(id_inst),  64'(0));
    check({tag, "_count"}, 64'(count),    64'(0));
  endtask

  logic [31:0] exp_pc [8];

  initial begin
    rst = 1'b0; stall = '0; flush = 1'b0;
    idle();
    #12;
    empty_is("rst0");
    check("rst0_ready", 64'(if_ready), 64'(1));
    check("rst0_sreq",  64'(stallreq_if), 64'(0));
    rst = 1'b1;
    step();

    // Pass-through with one-cycle latency, then bubble
    offer(32'h0040_0000);
    if_inst = 32'h2408_0005;
    step();
    idle();
    check("pt_pc",    64'(id_pc),    64'(32'h0040_0000));
    check("pt_inst",  64'(id_inst),  64'(32'h2408_0005));
    check("pt_valid", 64'(id_valid), 64'(1));
    step();
    empty_is("pt_bubble");

    // Fill under ID stall; 5th word refused, head held at 0x0
    stall = 6'b000100;
    for (int i = 0; i < 5; i++) begin
      offer(32'(i * 4));
      step();
      head_is($sformatf("fill%0d", i), 32'h0, 3'((i < 4) ? i + 1 : 4));
    end
    check("fill_ready", 64'(if_ready),    64'(0));
    check("fill_sreq",  64'(stallreq_if), 64'(1));

    // Drain with unrelated stall bits set; first offer (0x100) hits full and is lost
    stall = 6'b111011;
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h104, 32'h108, 32'h10C, 32'h110, 32'h0};
    offer(32'h100);
    step();
    head_is("drain0", exp_pc[0], 3'd3);
    for (int i = 1; i < 5; i++) begin
      offer(32'h100 + 32'(i * 4));
      step();
      head_is($sformatf("drain%0d", i), exp_pc[i], 3'd3);
    end
    idle();
    step();
    head_is("drain5", exp_pc[5], 3'd2);
    step();
    head_is("drain6", exp_pc[6], 3'd1);
    step();
    empty_is("drain_end");

    // Flush with concurrent push; pushed word must not survive
    stall = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      offer(32'h200 + 32'(i * 4));
      step();
    end
    head_is("fl_pre", 32'h200, 3'd3);
    stall = '0;
    flush = 1'b1;
    offer(32'h20C);
    step();
    flush = 1'b0;
    idle();
    empty_is("fl_post");
    step();
    empty_is("fl_post2");

    // Flush while full and stalled
    stall = 6'b000100;
    for (int i = 0; i < 4; i++) begin
      offer(32'h280 + 32'(i * 4));
      step();
    end
    check("flf_sreq", 64'(stallreq_if), 64'(1));
    flush = 1'b1;
    idle();
    step();
    flush = 1'b0;
    empty_is("flf_post");
    check("flf_ready", 64'(if_ready), 64'(1));

    // Full + pop + offered push
    for (int i = 0; i < 4; i++) begin
      offer(32'h300 + 32'(i * 4));
      step();
    end
    head_is("fpp_pre", 32'h300, 3'd4);
    stall = '0;
    offer(32'h310);
    step();
    idle();
    head_is("fpp0", 32'h304, 3'd3);
    step();
    head_is("fpp1", 32'h308, 3'd2);
    step();
    head_is("fpp2", 32'h30C, 3'd1);
    step();
    empty_is("fpp_end");

    // Async reset mid-cycle with count=3
    stall = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      offer(32'h400 + 32'(i * 4));
      step();
    end
    idle();
    head_is("ar_pre", 32'h400, 3'd3);
    #1;
    rst = 1'b0;
    #1;
    empty_is("ar");
    check("ar_ready", 64'(if_ready),    64'(1));
    check("ar_sreq",  64'(stallreq_if), 64'(0));
    #1;
    rst = 1'b1;
    step();
    empty_is("ar_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
